dvp_frame_ctrl: RTL and testbench

//  Frame-level sequencer behind the DVP capture stage of the OV5640 path. Arms on cap_en or snap_req,

---
 rtl/dvp_ctrl_pkg.sv | 17 +
 rtl/dvp_edge_det.sv | 20 ++
 rtl/dvp_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dvp_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_ctrl_pkg.sv
// Shared constants for the DVP frame sequencer: FSM state codes, bus widths and
// a saturating increment used by the per-frame pixel counter.
package dvp_ctrl_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   localparam int PIX_W  = 16;
   localparam int ADDR_W = 12;
   localparam int CNT_W  = 16;

   function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dvp_edge_det.sv
// Rising-edge detector for the sensor vsync: one delay flop, edge = level & ~delayed.
module dvp_edge_det (
   input  logic pclk,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic sig_d, sig_q;

   always_comb sig_d = sig;

   always_ff @(posedge pclk) begin
      if (!rst_n) sig_q <= 1'b0;
      else        sig_q <= sig_d;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/dvp_frame_ctrl.sv
// Frame-level sequencer behind the DVP capture stage: arms, drops settling frames,
// then forwards whole frames only. Optional frame decimation under FRAME_DECIM_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | disarmed, waiting for cap_en or snap_req
// ST_SYNC   | armed, counting down settling frames on vsync rising edges
// ST_ACTIVE | forwarding pixels; each vsync rise closes a frame
// 3         | unused, falls back to ST_IDLE
module dvp_frame_ctrl
   import dvp_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int HEIGHT      = 12,
   parameter int SKIP_FRAMES = 2,
   parameter int DECIM       = 1
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             cap_en,
   input  logic             snap_req,
   input  logic             err_clr,
   input  logic             vsync,
   input  logic [PIX_W-1:0] datapixel,
   input  logic             datavalid,
   output logic [PIX_W-1:0] pix_data,
   output logic             pix_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             err_size
);

   localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(WIDTH * HEIGHT);
   localparam logic [7:0]        SKIP_LOAD = 8'(SKIP_FRAMES);

   if (SKIP_FRAMES < 0 || SKIP_FRAMES > 255 || DECIM < 1 || WIDTH * HEIGHT > 4095) begin : g_param_chk
      $error("dvp_frame_ctrl: parameter out of range");
   end

   logic              vs_rise;
   logic [1:0]        state_q, state_d;
   logic [7:0]        skip_q, skip_d;
   logic              snap_q, snap_d;
   logic [ADDR_W-1:0] pixcnt_q, pixcnt_d, pix_final;
   logic [PIX_W-1:0]  pix_data_q, pix_data_d;
   logic              pix_valid_q, pix_valid_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_end_q, frame_end_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              err_q, err_d, err_set;
   logic              fwd, fwd_next;

   dvp_edge_det u_vs_edge (
      .pclk  (pclk),
      .rst_n (rst_n),
      .sig   (vsync),
      .rise  (vs_rise)
   );

`ifdef FRAME_DECIM_EN
   localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);

   logic [15:0] decim_q, decim_d;

   // Held at zero outside ACTIVE so the first frame after SYNC is always forwarded.
   always_comb begin
      decim_d = decim_q;
      if (state_q != ST_ACTIVE)
         decim_d = '0;
      else if (vs_rise)
         decim_d = (decim_q >= DECIM_LAST) ? '0 : decim_q + 16'd1;
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) decim_q <= '0;
      else        decim_q <= decim_d;
   end

   assign fwd      = (decim_q == '0);
   assign fwd_next = (decim_d == '0);
`else
   assign fwd      = 1'b1;
   assign fwd_next = 1'b1;
`endif

   assign pix_final = (datavalid && fwd) ? sat_inc(pixcnt_q) : pixcnt_q;

   always_comb begin
      state_d       = state_q;
      skip_d        = skip_q;
      snap_d        = snap_q;
      pixcnt_d      = pixcnt_q;
      pix_valid_d   = 1'b0;
      pix_data_d    = '0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      err_set       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            snap_d = 1'b0;
            if (cap_en || snap_req) begin
               state_d = ST_SYNC;
               skip_d  = SKIP_LOAD;
               snap_d  = ~cap_en & snap_req;
            end
         end

         ST_SYNC: begin
            if (!cap_en && !snap_q) begin
               state_d = ST_IDLE;
            end else if (vs_rise) begin
               if (skip_q != 8'd0) begin
                  skip_d = skip_q - 8'd1;
               end else begin
                  state_d       = ST_ACTIVE;
                  frame_start_d = 1'b1;
                  pixcnt_d      = '0;
               end
            end
         end

         ST_ACTIVE: begin
            // A pixel coincident with the vsync rise still belongs to the closing frame.
            pix_valid_d = datavalid & fwd;
            pix_data_d  = (datavalid && fwd) ? datapixel : '0;
            pixcnt_d    = pix_final;
            if (vs_rise) begin
               pixcnt_d = '0;
               if (fwd) begin
                  frame_end_d = 1'b1;
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  err_set     = (pix_final != FRAME_PIX);
               end
               if (snap_q || !cap_en) begin
                  state_d = ST_IDLE;
                  snap_d  = 1'b0;
               end else begin
                  frame_start_d = fwd_next;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         skip_q        <= '0;
         snap_q        <= 1'b0;
         pixcnt_q      <= '0;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_cnt_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         skip_q        <= skip_d;
         snap_q        <= snap_d;
         pixcnt_q      <= pixcnt_d;
         pix_data_q    <= pix_data_d;
         pix_valid_q   <= pix_valid_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         frame_cnt_q   <= frame_cnt_d;
         err_q         <= err_d;
      end
   end

   assign pix_data    = pix_data_q;
   assign pix_valid   = pix_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign busy        = (state_q != ST_IDLE);
   assign state       = state_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_size    = err_q;

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// Randomized bench for dvp_frame_ctrl: a frame-level model decides which frames are
// forwarded and predicts pixels, strobes, frame count and the size-error flag.
module tb_dvp_frame_ctrl;

   localparam int WIDTH  = 8;
   localparam int HEIGHT = 12;
   localparam int SKIP   = 2;
`ifdef FRAME_DECIM_EN
   localparam int M_DECIM = 3;
`else
   localparam int M_DECIM = 1;
`endif

   logic        pclk = 1'b0;
   logic        rst_n, cap_en, snap_req, err_clr, vsync, datavalid;
   logic [15:0] datapixel;
   logic [15:0] pix_data;
   logic        pix_valid, frame_start, frame_end, busy, err_size;
   logic [1:0]  state;
   logic [15:0] frame_cnt;

   dvp_frame_ctrl #(
      .WIDTH       (WIDTH),
      .HEIGHT      (HEIGHT),
      .SKIP_FRAMES (SKIP),
      .DECIM       (3)
   ) dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .cap_en      (cap_en),
      .snap_req    (snap_req),
      .err_clr     (err_clr),
      .vsync       (vsync),
      .datapixel   (datapixel),
      .datavalid   (datavalid),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .busy        (busy),
      .state       (state),
      .frame_cnt   (frame_cnt),
      .err_size    (err_size)
   );

   always #40 pclk = ~pclk;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] exp_q[$];
   int          pv_cnt, fs_cnt, fe_cnt, exp_pix_total;
   int          last_f;
   int          lines_of[0:63];
   logic [15:0] exp_cnt;
   logic        exp_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Frame j counts from the first vsync rise after arming.
   function automatic bit fwd(input int j);
      if (j < 1 || j > last_f || j <= SKIP) return 1'b0;
      return ((j - SKIP - 1) % M_DECIM) == 0;
   endfunction

   always @(negedge pclk) begin
      if (pix_valid) begin
         pv_cnt++;
         chk("pix_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) chk("pix_data", pix_data, exp_q.pop_front());
      end
      if (frame_start) fs_cnt++;
      if (frame_end)   fe_cnt++;
   end

   task automatic push_pix(input int k, input logic [15:0] d);
      if (fwd(k)) begin
         exp_q.push_back(d);
         exp_pix_total++;
      end
   endtask

   // Rising vsync: closes frame k-1, opens frame k.
   task automatic vs_pulse(input int k, input bit co_pix, input bit clr);
      bit set;
      @(negedge pclk);
      vsync     = 1'b1;
      err_clr   = clr;
      datavalid = co_pix;
      if (co_pix) begin
         datapixel = 16'($urandom);
         push_pix(k - 1, datapixel);
      end
      set = fwd(k - 1) && (lines_of[k - 1] * WIDTH != WIDTH * HEIGHT);
      if (fwd(k - 1)) exp_cnt++;
      if (set)      exp_err = 1'b1;
      else if (clr) exp_err = 1'b0;
      @(negedge pclk);
      datavalid = 1'b0;
      err_clr   = 1'b0;
      chk("frame_end",   frame_end,   fwd(k - 1));
      chk("frame_start", frame_start, fwd(k));
      chk("frame_cnt",   frame_cnt,   exp_cnt);
      chk("err_size",    err_size,    exp_err);
      @(negedge pclk);
      vsync = 1'b0;
   endtask

   task automatic pixels(input int k, input int n, input int drop_at);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge pclk);
            datavalid = 1'b0;
         end
         @(negedge pclk);
         datavalid = 1'b1;
         datapixel = 16'($urandom);
         push_pix(k, datapixel);
         if (i == drop_at) cap_en = 1'b0;
         if (i % WIDTH == WIDTH - 1) begin
            @(negedge pclk);
            datavalid = 1'b0;
         end
      end
      @(negedge pclk);
      datavalid = 1'b0;
   endtask

   task automatic run_capture(input int nframes, input bit snap, input int stop,
                              input int short_mask, input int clr_mask);
      bit co;
      int n, drop, n_fwd;
      for (int j = 0; j < 64; j++)
         lines_of[j] = (j < 32 && short_mask[j]) ? HEIGHT - 1 : HEIGHT;
      last_f        = snap ? SKIP + 1 : stop;
      pv_cnt        = 0;
      fs_cnt        = 0;
      fe_cnt        = 0;
      exp_pix_total = 0;
      n_fwd         = 0;
      for (int j = 1; j <= nframes; j++) if (fwd(j)) n_fwd++;

      @(negedge pclk);
      if (snap) begin
         snap_req = 1'b1;
         cap_en   = 1'b0;
      end else begin
         cap_en = 1'b1;
      end
      @(negedge pclk);
      snap_req = 1'b0;
      repeat (2) @(negedge pclk);
      chk("busy_armed", busy, 1);

      co = 1'b0;
      for (int k = 1; k <= nframes; k++) begin
         vs_pulse(k, co, (k < 32) && clr_mask[k]);
         co   = 1'($urandom_range(0, 1));
         n    = lines_of[k] * WIDTH - int'(co);
         drop = -1;
         if (!snap && k == stop)
            drop = $urandom_range(0, lines_of[k] - 2) * WIDTH + $urandom_range(1, WIDTH - 2);
         pixels(k, n, drop);
      end
      vs_pulse(nframes + 1, co, (nframes + 1 < 32) && clr_mask[nframes + 1]);
      cap_en = 1'b0;
      repeat (4) @(negedge pclk);

      chk("pix_total",   pv_cnt, exp_pix_total);
      chk("pix_leftover", exp_q.size(), 0);
      chk("start_count", fs_cnt, n_fwd);
      chk("end_count",   fe_cnt, n_fwd);
      chk("state_idle",  state, 0);
      chk("busy_idle",   busy, 0);
   endtask

   initial begin
      #(80 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cap_en = 1'b0; snap_req = 1'b0; err_clr = 1'b0;
      vsync = 1'b0; datavalid = 1'b0; datapixel = '0;
      exp_cnt = '0; exp_err = 1'b0; last_f = 0;
      for (int j = 0; j < 64; j++) lines_of[j] = HEIGHT;
      repeat (3) @(negedge pclk);
      chk("rst_state",     state, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_err",       err_size, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge pclk);

      // continuous capture, 5 frames
      run_capture(5, 1'b0, 5, 0, 0);
      // single snapshot, later frames must be ignored
      run_capture(4, 1'b1, 0, 0, 0);
      // cap_en dropped mid-line in the first forwarded frame
      run_capture(6, 1'b0, 3, 0, 0);
      // short frames 3 and 5; clear on pulse 5 wins, clear on pulse 6 loses to new error
      run_capture(6, 1'b0, 6, 32'h28, 32'h60);
      // decimation window: 9 frames after the settling frames
      run_capture(11, 1'b0, 11, 0, 32'h2);

      for (int r = 0; r < 3; r++) begin
         int nf;
         nf = $urandom_range(3, 6);
         run_capture(nf, 1'($urandom_range(0, 1)), $urandom_range(SKIP + 1, nf),
                     int'($urandom & 32'h7E), int'($urandom & 32'hFE));
      end

      // reset in the middle of a forwarded frame
      last_f = 100;
      for (int j = 0; j < 64; j++) lines_of[j] = HEIGHT;
      @(negedge pclk);
      cap_en = 1'b1;
      repeat (2) @(negedge pclk);
      vs_pulse(1, 1'b0, 1'b0);
      vs_pulse(2, 1'b0, 1'b0);
      vs_pulse(3, 1'b0, 1'b0);
      pixels(3, 20, -1);
      @(negedge pclk);
      datavalid = 1'b1;
      datapixel = 16'($urandom);
      rst_n     = 1'b0;
      cap_en    = 1'b0;
      @(negedge pclk);
      rst_n     = 1'b1;
      datavalid = 1'b0;
      chk("midrst_pix_valid",   pix_valid, 0);
      chk("midrst_pix_data",    pix_data, 0);
      chk("midrst_state",       state, 0);
      chk("midrst_busy",        busy, 0);
      chk("midrst_frame_cnt",   frame_cnt, 0);
      chk("midrst_frame_start", frame_start, 0);
      chk("midrst_frame_end",   frame_end, 0);
      chk("midrst_err",         err_size, 0);
      repeat (4) @(negedge pclk);
      chk("postrst_pix_valid",  pix_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
